// File: rtl/ex_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_pipe
//  Description : Execute-stage pipeline register with write-back select.
//                Captures the ALU result or the load data, chosen by reg_flag,
//                together with the destination index and control bits. The
//                outputs drive the register-file write port one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_flag,
    input  logic [DATA_W-1:0] result,
    input  logic              reg_wr_en,
    input  logic [REG_AW-1:0] rd,
    input  logic [DATA_W-1:0] data_in,
    output logic              reg_wr_en2,
    output logic [REG_AW-1:0] rd_out,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] write_data,
    output logic              flag_out
);

    // Register x0 is hard-wired to zero, so any write aimed at it is dropped.
    localparam logic [REG_AW-1:0] c_REG_ZERO = '0;

    logic              wr_en_d,      wr_en_q;
    logic [REG_AW-1:0] rd_d,         rd_q;
    logic [DATA_W-1:0] data_d,       data_q;
    logic [DATA_W-1:0] write_data_d, write_data_q;
    logic              flag_d,       flag_q;

    // Next-state values: write-back mux and x0 write suppression.
    always_comb begin
        flag_d       = reg_flag;
        rd_d         = rd;
        data_d       = data_in;
        write_data_d = reg_flag ? data_in : result;
        wr_en_d      = reg_wr_en & (rd != c_REG_ZERO);
    end

    // Pipeline register; reset discards the in-flight entry and blocks the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            rd_q         <= '0;
            data_q       <= '0;
            write_data_q <= '0;
            flag_q       <= 1'b0;
        end else begin
            wr_en_q      <= wr_en_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            write_data_q <= write_data_d;
            flag_q       <= flag_d;
        end
    end

    // All outputs come straight from flops; no input-to-output combinational path.
    assign reg_wr_en2 = wr_en_q;
    assign rd_out     = rd_q;
    assign data_out   = data_q;
    assign write_data = write_data_q;
    assign flag_out   = flag_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage_pipe
//  Description : Directed self-checking bench for ex_stage_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage_pipe;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk;
    logic              rst;
    logic              reg_flag;
    logic [DATA_W-1:0] result;
    logic              reg_wr_en;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data_in;
    logic              reg_wr_en2;
    logic [REG_AW-1:0] rd_out;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] write_data;
    logic              flag_out;

    int checks;
    int failures;

    ex_stage_pipe #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_flag   (reg_flag),
        .result     (result),
        .reg_wr_en  (reg_wr_en),
        .rd         (rd),
        .data_in    (data_in),
        .reg_wr_en2 (reg_wr_en2),
        .rd_out     (rd_out),
        .data_out   (data_out),
        .write_data (write_data),
        .flag_out   (flag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_we, input logic [REG_AW-1:0] e_rd,
                           input logic [DATA_W-1:0] e_do, input logic [DATA_W-1:0] e_wd,
                           input logic e_fl);
        chk({tag, ".reg_wr_en2"}, 32'(reg_wr_en2), 32'(e_we));
        chk({tag, ".rd_out"},     32'(rd_out),     32'(e_rd));
        chk({tag, ".data_out"},   data_out,        e_do);
        chk({tag, ".write_data"}, write_data,      e_wd);
        chk({tag, ".flag_out"},   32'(flag_out),   32'(e_fl));
    endtask

    // Drive one entry on the falling edge, then let one rising edge capture it.
    task automatic cycle(input logic r, input logic f, input logic [DATA_W-1:0] res,
                         input logic we, input logic [REG_AW-1:0] d_rd,
                         input logic [DATA_W-1:0] din);
        @(negedge clk);
        rst       = r;
        reg_flag  = f;
        result    = res;
        reg_wr_en = we;
        rd        = d_rd;
        data_in   = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic              f, we;
        logic [DATA_W-1:0] res, din;
        logic [REG_AW-1:0] r_idx;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        reg_flag  = 1'b0;
        result    = '0;
        reg_wr_en = 1'b0;
        rd        = '0;
        data_in   = '0;

        // Reset held for two edges with random inputs.
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'($urandom), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
            chk_all("reset", 1'b0, '0, '0, '0, 1'b0);
        end

        // Load write-back selects data_in.
        cycle(1'b0, 1'b1, 32'hAAAA_AAAA, 1'b1, 5'b10010, 32'h5555_5555);
        chk_all("load", 1'b1, 5'b10010, 32'h5555_5555, 32'h5555_5555, 1'b1);

        // ALU write-back selects result.
        cycle(1'b0, 1'b0, 32'h1234_5678, 1'b1, 5'b01100, 32'h8765_4321);
        chk_all("alu", 1'b1, 5'b01100, 32'h8765_4321, 32'h1234_5678, 1'b0);

        // Write to x0 is suppressed but data still captured.
        cycle(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'h0BAD_F00D);
        chk_all("x0", 1'b0, 5'd0, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b0);

        // reg_wr_en low: no write, index and data still captured.
        cycle(1'b0, 1'b1, 32'h0000_0001, 1'b0, 5'd31, 32'hFFFF_FFFF);
        chk_all("no_wr", 1'b0, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        // Back-to-back random stream, with a mid-cycle stability check.
        for (int i = 0; i < 8; i++) begin
            f     = 1'($urandom);
            we    = 1'($urandom);
            res   = $urandom;
            din   = $urandom;
            r_idx = (i == 3) ? 5'd0 : 5'($urandom);
            cycle(1'b0, f, res, we, r_idx, din);
            chk_all($sformatf("stream%0d", i), we & (r_idx != 5'd0), r_idx, din,
                    f ? din : res, f);
            #3;
            chk_all($sformatf("stable%0d", i), we & (r_idx != 5'd0), r_idx, din,
                    f ? din : res, f);
        end

        // Mid-stream reset discards the in-flight entry.
        cycle(1'b1, 1'b1, 32'hCAFE_0001, 1'b1, 5'd7, 32'hCAFE_0002);
        chk_all("mid_rst", 1'b0, '0, '0, '0, 1'b0);

        // Capture resumes on the edge after reset is released.
        cycle(1'b0, 1'b0, 32'h0000_00A5, 1'b1, 5'd7, 32'h0000_005A);
        chk_all("resume", 1'b1, 5'd7, 32'h0000_005A, 32'h0000_00A5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
